// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter and its scoreboard.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MDU  = 2'd2
  } gnt_e;

  function automatic logic is_reg_zero(input logic [ADDR_W-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard for outstanding MDU destinations plus the outstanding-op counter.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int MDU_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              retire_i,
  input  logic [ADDR_W-1:0] retire_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic              issue_full_o,
  output logic              busy_a_o,
  output logic              busy_b_o
);

  localparam int CNT_W = $clog2(MDU_DEPTH + 1);

  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                issue_ok;
  logic                retire_ok;

  assign issue_full_o = (out_cnt_q == CNT_W'(MDU_DEPTH));
  assign issue_ok     = issue_i & ~issue_full_o;
  // Guard against a stray retire underflowing the counter.
  assign retire_ok    = retire_i & (out_cnt_q != '0);

  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({issue_ok, retire_ok})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Per-register busy bit; a same-cycle issue to the retiring address wins.
  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_busy
      if (g == 0) begin : g_zero
        assign busy_d[g] = 1'b0;
      end else begin : g_reg
        always_comb begin
          busy_d[g] = busy_q[g];
          if (issue_ok && issue_addr_i == ADDR_W'(g))
            busy_d[g] = 1'b1;
          else if (retire_i && retire_addr_i == ADDR_W'(g))
            busy_d[g] = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
      busy_q    <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_a_o = busy_q[rd_addr_a_i];
  assign busy_b_o = busy_q[rd_addr_b_i];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register file's single write port between WB and the MDU,
// with an anti-starvation wait counter and a registered write port.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT  = 3,
  parameter int MDU_DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              WbValid,
  input  logic [ADDR_W-1:0] WbAddr,
  input  logic [DATA_W-1:0] WbData,
  output logic              WbReady,
  input  logic              MduIssue,
  input  logic [ADDR_W-1:0] MduIssueAddr,
  output logic              IssueFull,
  input  logic              MduValid,
  input  logic [ADDR_W-1:0] MduAddr,
  input  logic [DATA_W-1:0] MduData,
  output logic              MduReady,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic              BusyA,
  output logic              BusyB,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] RegWrAddr,
  output logic [DATA_W-1:0] RegWrData
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  gnt_e              gnt;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              reg_we_q, reg_we_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_data_q, reg_data_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // WB normally wins; an MDU result that has waited MAX_WAIT cycles takes the port.
  always_comb begin
    gnt = GNT_NONE;
    if (MduValid && (!WbValid || wait_cnt_q == WAIT_W'(MAX_WAIT)))
      gnt = GNT_MDU;
    else if (WbValid)
      gnt = GNT_WB;
  end

  assign MduReady = (gnt == GNT_MDU);
  assign WbReady  = (gnt == GNT_WB);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (MduValid && MduReady)
      wait_cnt_d = '0;
    else if (MduValid && wait_cnt_q != WAIT_W'(MAX_WAIT))
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign sel_addr = (gnt == GNT_MDU) ? MduAddr : WbAddr;
  assign sel_data = (gnt == GNT_MDU) ? MduData : WbData;

  // Register-0 writes are accepted but never reach the register file.
  always_comb begin
    reg_we_d   = (gnt != GNT_NONE) && !is_reg_zero(sel_addr);
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    if (reg_we_d) begin
      reg_addr_d = sel_addr;
      reg_data_d = sel_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wait_cnt_q <= '0;
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      reg_we_q   <= reg_we_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
    end
  end

  assign RegWrite  = reg_we_q;
  assign RegWrAddr = reg_addr_q;
  assign RegWrData = reg_data_q;

  reg_scoreboard #(
    .MDU_DEPTH(MDU_DEPTH)
  ) u_sb (
    .clk          (Clk),
    .rst_n        (Rst_n),
    .issue_i      (MduIssue),
    .issue_addr_i (MduIssueAddr),
    .retire_i     (MduValid & MduReady),
    .retire_addr_i(MduAddr),
    .rd_addr_a_i  (RdAddrA),
    .rd_addr_b_i  (RdAddrB),
    .issue_full_o (IssueFull),
    .busy_a_o     (BusyA),
    .busy_b_o     (BusyB)
  );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scenario tasks plus a randomized run against a queue-based reference model.
module tb_regfile_wr_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        WbValid, MduIssue, MduValid;
  logic [4:0]  WbAddr, MduIssueAddr, MduAddr, RdAddrA, RdAddrB;
  logic [31:0] WbData, MduData;
  logic        WbReady, IssueFull, MduReady, BusyA, BusyB, RegWrite;
  logic [4:0]  RegWrAddr;
  logic [31:0] RegWrData;

  int total = 0;
  int bad = 0;

  logic [31:0] rf [32];

  regfile_wr_arbiter dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData), .WbReady(WbReady),
    .MduIssue(MduIssue), .MduIssueAddr(MduIssueAddr), .IssueFull(IssueFull),
    .MduValid(MduValid), .MduAddr(MduAddr), .MduData(MduData), .MduReady(MduReady),
    .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .BusyA(BusyA), .BusyB(BusyB),
    .RegWrite(RegWrite), .RegWrAddr(RegWrAddr), .RegWrData(RegWrData)
  );

  always #5 Clk = ~Clk;

  // Register file model: commits on the falling edge.
  always @(negedge Clk) if (RegWrite) rf[RegWrAddr] <= RegWrData;

  task automatic idle();
    WbValid = 0; WbAddr = 0; WbData = 0;
    MduIssue = 0; MduIssueAddr = 0;
    MduValid = 0; MduAddr = 0; MduData = 0;
  endtask

  task automatic next_cycle();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    idle(); RdAddrA = 0; RdAddrB = 0;
    Rst_n = 0;
    repeat (2) @(posedge Clk);
    #2 Rst_n = 1;
    #1;
    total++; if (RegWrite !== 1'b0 || RegWrAddr !== 5'd0 || RegWrData !== 32'd0) begin
      bad++; $display("FAIL reset_regwr: we=%0b addr=%0d data=%h want 0/0/0", RegWrite, RegWrAddr, RegWrData); end
    total++; if (IssueFull !== 1'b0 || BusyA !== 1'b0 || BusyB !== 1'b0) begin
      bad++; $display("FAIL reset_sb: full=%0b busyA=%0b busyB=%0b want 0", IssueFull, BusyA, BusyB); end
    // Build up traffic, then hit reset mid-cycle.
    next_cycle(); MduIssue = 1; MduIssueAddr = 3;
    next_cycle(); MduIssueAddr = 4; WbValid = 1; WbAddr = 6; WbData = 32'h1111_2222;
    next_cycle(); idle(); RdAddrA = 3; RdAddrB = 4; #1;
    total++; if (RegWrite !== 1'b1 || BusyA !== 1'b1 || BusyB !== 1'b1 || IssueFull !== 1'b1) begin
      bad++; $display("FAIL pre_reset: we=%0b busyA=%0b busyB=%0b full=%0b want 1/1/1/1", RegWrite, BusyA, BusyB, IssueFull); end
    #1 Rst_n = 0; #1;
    total++; if (RegWrite !== 1'b0 || BusyA !== 1'b0 || BusyB !== 1'b0 || IssueFull !== 1'b0) begin
      bad++; $display("FAIL async_reset: we=%0b busyA=%0b busyB=%0b full=%0b want 0", RegWrite, BusyA, BusyB, IssueFull); end
    @(negedge Clk); Rst_n = 1;
  endtask

  task automatic test_wb_only();
    next_cycle(); idle();
    WbValid = 1; WbAddr = 5; WbData = 32'hDEADBEEF; #1;
    total++; if (WbReady !== 1'b1 || MduReady !== 1'b0) begin
      bad++; $display("FAIL wb_ready: wbrdy=%0b mdurdy=%0b want 1/0", WbReady, MduReady); end
    next_cycle(); idle(); #1;
    total++; if (RegWrite !== 1'b1 || RegWrAddr !== 5'd5 || RegWrData !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wb_regwr: we=%0b addr=%0d data=%h want 1/5/deadbeef", RegWrite, RegWrAddr, RegWrData); end
    @(negedge Clk); #1;
    total++; if (rf[5] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wb_commit: rf5=%h want deadbeef", rf[5]); end
    next_cycle(); #1;
    total++; if (RegWrite !== 1'b0 || RegWrAddr !== 5'd5) begin
      bad++; $display("FAIL wb_hold: we=%0b addr=%0d want 0/5", RegWrite, RegWrAddr); end
  endtask

  task automatic test_starvation();
    next_cycle(); idle(); MduIssue = 1; MduIssueAddr = 9;
    next_cycle(); idle();
    WbValid = 1; WbAddr = 1; WbData = 32'h0000_00AA;
    MduValid = 1; MduAddr = 9; MduData = 32'hCAFE_0009;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (MduReady !== (c == 3) || WbReady !== (c != 3)) begin
        bad++; $display("FAIL starve_c%0d: mdurdy=%0b wbrdy=%0b want %0b/%0b", c, MduReady, WbReady, c == 3, c != 3); end
      next_cycle();
    end
    #1;
    total++; if (RegWrite !== 1'b1 || RegWrAddr !== 5'd9 || RegWrData !== 32'hCAFE_0009) begin
      bad++; $display("FAIL starve_regwr: we=%0b addr=%0d data=%h want 1/9/cafe0009", RegWrite, RegWrAddr, RegWrData); end
    total++; if (MduReady !== 1'b0 || WbReady !== 1'b1) begin
      bad++; $display("FAIL starve_waitclr: mdurdy=%0b wbrdy=%0b want 0/1", MduReady, WbReady); end
    MduValid = 0;
    next_cycle(); idle(); RdAddrA = 9; #1;
    total++; if (BusyA !== 1'b0 || IssueFull !== 1'b0) begin
      bad++; $display("FAIL starve_sb: busy9=%0b full=%0b want 0/0", BusyA, IssueFull); end
  endtask

  task automatic test_scoreboard();
    next_cycle(); idle(); MduIssue = 1; MduIssueAddr = 7;
    next_cycle(); MduIssueAddr = 8;
    next_cycle(); MduIssueAddr = 10; #1;
    total++; if (IssueFull !== 1'b1) begin
      bad++; $display("FAIL sb_full: full=%0b want 1", IssueFull); end
    next_cycle(); idle(); RdAddrA = 10; RdAddrB = 8; #1;
    total++; if (BusyA !== 1'b0 || BusyB !== 1'b1) begin
      bad++; $display("FAIL sb_ignored: busy10=%0b busy8=%0b want 0/1", BusyA, BusyB); end
    RdAddrA = 7; #1;
    total++; if (BusyA !== 1'b1) begin
      bad++; $display("FAIL sb_busy7: busy7=%0b want 1", BusyA); end
    MduValid = 1; MduAddr = 7; MduData = 32'h77; #1;
    total++; if (MduReady !== 1'b1) begin
      bad++; $display("FAIL sb_retire_rdy: mdurdy=%0b want 1", MduReady); end
    next_cycle(); idle(); #1;
    total++; if (BusyA !== 1'b0 || BusyB !== 1'b1 || IssueFull !== 1'b0) begin
      bad++; $display("FAIL sb_retire: busy7=%0b busy8=%0b full=%0b want 0/1/0", BusyA, BusyB, IssueFull); end
    MduValid = 1; MduAddr = 8;
    next_cycle(); idle(); #1;
    total++; if (BusyB !== 1'b0) begin
      bad++; $display("FAIL sb_retire8: busy8=%0b want 0", BusyB); end
  endtask

  task automatic test_simultaneous();
    next_cycle(); idle(); MduIssue = 1; MduIssueAddr = 7;
    next_cycle(); MduValid = 1; MduAddr = 7; MduData = 32'h7;
    next_cycle(); idle(); RdAddrA = 7; #1;
    total++; if (BusyA !== 1'b1 || IssueFull !== 1'b0) begin
      bad++; $display("FAIL simul_busy: busy7=%0b full=%0b want 1/0", BusyA, IssueFull); end
    MduIssue = 1; MduIssueAddr = 12;
    next_cycle(); idle(); #1;
    total++; if (IssueFull !== 1'b1) begin
      bad++; $display("FAIL simul_cnt: full=%0b want 1", IssueFull); end
    MduValid = 1; MduAddr = 7;
    next_cycle(); MduAddr = 12;
    next_cycle(); idle(); RdAddrB = 12; #1;
    total++; if (IssueFull !== 1'b0 || BusyA !== 1'b0 || BusyB !== 1'b0) begin
      bad++; $display("FAIL simul_drain: full=%0b busy7=%0b busy12=%0b want 0", IssueFull, BusyA, BusyB); end
  endtask

  task automatic test_zero_reg();
    next_cycle(); idle(); WbValid = 1; WbAddr = 0; WbData = 32'h1234; #1;
    total++; if (WbReady !== 1'b1) begin
      bad++; $display("FAIL zero_wbrdy: wbrdy=%0b want 1", WbReady); end
    next_cycle(); idle(); MduIssue = 1; MduIssueAddr = 0; #1;
    total++; if (RegWrite !== 1'b0) begin
      bad++; $display("FAIL zero_wbwe: we=%0b want 0", RegWrite); end
    next_cycle(); RdAddrA = 0;
    next_cycle(); idle(); #1;
    total++; if (BusyA !== 1'b0 || IssueFull !== 1'b1) begin
      bad++; $display("FAIL zero_issue: busy0=%0b full=%0b want 0/1", BusyA, IssueFull); end
    MduValid = 1; MduAddr = 0; MduData = 32'h55; #1;
    total++; if (MduReady !== 1'b1) begin
      bad++; $display("FAIL zero_mdurdy: mdurdy=%0b want 1", MduReady); end
    next_cycle(); #1;
    total++; if (RegWrite !== 1'b0) begin
      bad++; $display("FAIL zero_mduwe: we=%0b want 0", RegWrite); end
    next_cycle(); idle(); #1;
    total++; if (IssueFull !== 1'b0) begin
      bad++; $display("FAIL zero_drain: full=%0b want 0", IssueFull); end
  endtask

  task automatic test_random();
    bit [31:0]   m_busy = '0;
    int          m_q[$];
    int          m_wait = 0;
    bit          exp_we = 0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;
    bit          mdu_g, wb_g, full;
    idle();
    @(negedge Clk); Rst_n = 0;
    @(negedge Clk); Rst_n = 1;
    for (int n = 0; n < 400; n++) begin
      next_cycle(); idle();
      WbValid = ($urandom_range(0, 1) == 1);
      WbAddr  = 5'($urandom_range(0, 31));
      WbData  = $urandom;
      if (m_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        MduValid = 1; MduAddr = 5'(m_q[0]); MduData = $urandom;
      end
      MduIssue     = ($urandom_range(0, 2) == 0);
      MduIssueAddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      RdAddrA = (m_q.size() > 0 && $urandom_range(0, 1) == 1) ? 5'(m_q[0]) : 5'($urandom_range(0, 31));
      RdAddrB = 5'($urandom_range(0, 31));
      #1;
      full  = (m_q.size() == 2);
      mdu_g = MduValid && (!WbValid || m_wait == 3);
      wb_g  = WbValid && !mdu_g;
      total++; if (MduReady !== mdu_g || WbReady !== wb_g) begin
        bad++; $display("FAIL rnd_grant[%0d]: mdurdy=%0b wbrdy=%0b want %0b/%0b", n, MduReady, WbReady, mdu_g, wb_g); end
      total++; if (IssueFull !== full || BusyA !== m_busy[RdAddrA] || BusyB !== m_busy[RdAddrB]) begin
        bad++; $display("FAIL rnd_sb[%0d]: full=%0b A=%0b B=%0b want %0b/%0b/%0b", n, IssueFull, BusyA, BusyB, full, m_busy[RdAddrA], m_busy[RdAddrB]); end
      total++; if (RegWrite !== exp_we || (exp_we && (RegWrAddr !== exp_addr || RegWrData !== exp_data))) begin
        bad++; $display("FAIL rnd_regwr[%0d]: we=%0b addr=%0d data=%h want %0b/%0d/%h", n, RegWrite, RegWrAddr, RegWrData, exp_we, exp_addr, exp_data); end
      // Advance the model across the coming rising edge.
      exp_we = 0;
      if (mdu_g && MduAddr != 0) begin exp_we = 1; exp_addr = MduAddr; exp_data = MduData; end
      else if (wb_g && WbAddr != 0) begin exp_we = 1; exp_addr = WbAddr; exp_data = WbData; end
      if (mdu_g) begin
        m_busy[MduAddr] = 0; void'(m_q.pop_front()); m_wait = 0;
      end else if (MduValid && m_wait < 3) m_wait++;
      if (MduIssue && !full) begin
        m_q.push_back(int'(MduIssueAddr));
        if (MduIssueAddr != 0) m_busy[MduIssueAddr] = 1;
      end
    end
  endtask

  initial begin
    idle(); RdAddrA = 0; RdAddrB = 0;
    test_reset();
    test_wb_only();
    test_starvation();
    test_scoreboard();
    test_simultaneous();
    test_zero_reg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
